// File: rtl/countdown_timer_core_if.sv
// rtl/countdown_timer_core_if.sv - button inputs and display outputs of the countdown timer
interface countdown_timer_core_if;
  logic       btn_up;
  logic       btn_down;
  logic       start;
  logic       stop;
  logic [5:0] seg;
  logic       alarm;
  logic       running;

  modport master (
    output btn_up, btn_down, start, stop,
    input  seg, alarm, running
  );

  modport slave (
    input  btn_up, btn_down, start, stop,
    output seg, alarm, running
  );
endinterface

// File: rtl/countdown_timer_core.sv
// rtl/countdown_timer_core.sv - seconds countdown timer with alarm; AUTO_RELOAD_EN enables re-run after alarm timeout
module countdown_timer_core #(
  parameter int CLK_DIV     = 50000000,
  parameter int ALARM_TICKS = 5,
  parameter int MAX_VAL     = 59
) (
  input logic             clk,
  input logic             rst_n,
  countdown_timer_core_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [AW-1:0] ALARM_ONE  = AW'(1);
  localparam logic [5:0]    MAX6       = 6'(MAX_VAL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  state_t        state, state_n;
  logic [5:0]    preset, preset_n;
  logic [5:0]    count, count_n;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt, acnt_n;
  logic          up_q, down_q, start_q, stop_q;
  logic          up_edge, down_edge, start_edge, stop_edge;
  logic          tick;

  assign up_edge    = bus.btn_up   & ~up_q;
  assign down_edge  = bus.btn_down & ~down_q;
  assign start_edge = bus.start    & ~start_q;
  assign stop_edge  = bus.stop     & ~stop_q;
  assign tick = ((state == S_RUN) || (state == S_ALARM)) && (presc == PRESC_LAST);

  // Button history: one register per button so a held button acts once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      up_q    <= bus.btn_up;
      down_q  <= bus.btn_down;
      start_q <= bus.start;
      stop_q  <= bus.stop;
    end
  end

  // State register together with preset, count, prescaler and alarm counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      preset <= '0;
      count  <= '0;
      presc  <= '0;
      acnt   <= '0;
    end else begin
      state  <= state_n;
      preset <= preset_n;
      count  <= count_n;
      presc  <= presc_n;
      acnt   <= acnt_n;
    end
  end

  // Next-state logic; the alarm counter is zero whenever we are not alarming
  always_comb begin
    state_n  = state;
    preset_n = preset;
    count_n  = count;
    presc_n  = presc;
    acnt_n   = '0;

    if ((state == S_RUN) || (state == S_ALARM))
      presc_n = tick ? '0 : presc + PRESC_ONE;

    case (state)
      S_IDLE: begin
        if (up_edge && !down_edge)
          preset_n = (preset == MAX6) ? 6'd0 : preset + 6'd1;
        else if (down_edge && !up_edge)
          preset_n = (preset == 6'd0) ? MAX6 : preset - 6'd1;
        if (start_edge && (preset != 6'd0)) begin
          state_n = S_RUN;
          count_n = preset;
          presc_n = '0;
        end
      end
      S_RUN: begin
        // A stop landing on a tick wins: pause without decrementing
        if (stop_edge)
          state_n = S_PAUSE;
        else if (tick) begin
          count_n = count - 6'd1;
          if (count == 6'd1)
            state_n = S_ALARM;
        end
      end
      S_PAUSE: begin
        if (stop_edge)
          state_n = S_IDLE;
        else if (start_edge)
          state_n = S_RUN;
      end
      S_ALARM: begin
        acnt_n = acnt;
        if (stop_edge || start_edge) begin
          state_n = S_IDLE;
          acnt_n  = '0;
        end else if (tick) begin
          if (acnt == ALARM_LAST) begin
            acnt_n = '0;
`ifdef AUTO_RELOAD_EN
            state_n = S_RUN;
            count_n = preset;
            presc_n = '0;
`else
            state_n = S_IDLE;
`endif
          end else begin
            acnt_n = acnt + ALARM_ONE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output register: display value and flags follow the current state one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg     <= '0;
      bus.alarm   <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  bus.seg <= preset;
        S_ALARM: bus.seg <= 6'd0;
        default: bus.seg <= count;
      endcase
      bus.alarm   <= (state == S_ALARM);
      bus.running <= (state == S_RUN);
    end
  end

endmodule

// File: tb/tb_countdown_timer_core.sv
// tb/tb_countdown_timer_core.sv - self-checking bench for countdown_timer_core
module tb_countdown_timer_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_core_if bus();

  countdown_timer_core #(.CLK_DIV(4), .ALARM_TICKS(5), .MAX_VAL(59)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       up;
    logic       down;
    logic       start;
    logic       stop;
    int         hold;
    logic [5:0] seg;
    logic       alarm;
    logic       running;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] seg;
    logic       alarm;
    logic       running;
    string      name;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic u, input logic d, input logic s, input logic t);
    bus.btn_up   = u;
    bus.btn_down = d;
    bus.start    = s;
    bus.stop     = t;
  endtask

  task automatic pulse(input logic u, input logic d, input logic s, input logic t);
    drive(u, d, s, t);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
  endtask

  task automatic push_exp(input string n, input logic [5:0] s, input logic a, input logic r);
    exp_t e;
    e.seg = s;
    e.alarm = a;
    e.running = r;
    e.name = n;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sbq.pop_front();
      if (bus.seg !== e.seg || bus.alarm !== e.alarm || bus.running !== e.running) begin
        n_bad++;
        $display("FAIL %s: got seg=%0d alarm=%b running=%b, want seg=%0d alarm=%b running=%b",
                 e.name, bus.seg, bus.alarm, bus.running, e.seg, e.alarm, e.running);
      end
    end
  endtask

  task automatic check(input string n, input logic [5:0] s, input logic a, input logic r);
    push_exp(n, s, a, r);
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  6'd59, 1'b0, 1'b0, "down_wrap"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  6'd0,  1'b0, 1'b0, "up_wrap"};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  6'd1,  1'b0, 1'b0, "up_one"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  6'd1,  1'b0, 1'b0, "up_down_same"};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 20, 6'd2,  1'b0, 1'b0, "up_held"};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  6'd1,  1'b0, 1'b0, "down_one"};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  6'd0,  1'b0, 1'b0, "down_zero"};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  6'd0,  1'b0, 1'b0, "start_zero_guard"};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  6'd1,  1'b0, 1'b0, "preset_a"};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  6'd2,  1'b0, 1'b0, "preset_b"};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    check("reset_state", 6'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 10; i++) begin
      push_exp(vecs[i].name, vecs[i].seg, vecs[i].alarm, vecs[i].running);
      drive(vecs[i].up, vecs[i].down, vecs[i].start, vecs[i].stop);
      step(vecs[i].hold);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      step(1);
      pop_check();
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("preset3", 6'd3, 1'b0, 1'b0);

    // countdown 3,2,1,0 at 4-cycle steps, then alarm for 5 ticks
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("run_start", 6'd3, 1'b0, 1'b1);
    step(3);
    check("before_tick", 6'd3, 1'b0, 1'b1);
    step(1);
    check("tick_2", 6'd2, 1'b0, 1'b1);
    step(4);
    check("tick_1", 6'd1, 1'b0, 1'b1);
    step(3);
    check("before_expiry", 6'd1, 1'b0, 1'b1);
    step(1);
    check("expiry", 6'd0, 1'b1, 1'b0);
    step(19);
    check("alarm_last_cycle", 6'd0, 1'b1, 1'b0);
    step(1);
`ifdef AUTO_RELOAD_EN
    check("alarm_timeout_reload", 6'd3, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("reload_cancel", 6'd3, 1'b0, 1'b0);
`else
    check("alarm_timeout", 6'd3, 1'b0, 1'b0);
`endif

    // pause holds count and prescaler; resume continues the interrupted second
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("preset5", 6'd5, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    step(4);
    check("run_tick_4", 6'd4, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("paused", 6'd4, 1'b0, 1'b0);
    step(50);
    check("pause_frozen", 6'd4, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("resumed", 6'd4, 1'b0, 1'b1);
    step(1);
    check("resume_wait", 6'd4, 1'b0, 1'b1);
    step(1);
    check("resume_held_presc", 6'd3, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("paused2", 6'd3, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("cancel_idle", 6'd5, 1'b0, 1'b0);

    // acknowledge with STOP during alarm
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    step(20);
    check("alarm_5", 6'd0, 1'b1, 1'b0);
    step(3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("ack_pending", 6'd0, 1'b1, 1'b0);
    step(1);
    check("ack_stop", 6'd5, 1'b0, 1'b0);
    step(30);
    check("ack_stays_idle", 6'd5, 1'b0, 1'b0);

    // acknowledge with START during alarm returns to IDLE, not RUN
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    step(20);
    check("alarm_5b", 6'd0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("ack_start", 6'd5, 1'b0, 1'b0);
    step(10);
    check("ack_start_idle", 6'd5, 1'b0, 1'b0);

    // asynchronous reset in the middle of a countdown
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    step(5);
    check("pre_reset_running", 6'd4, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("reset_held_idle", 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_then_up3", 6'd3, 1'b0, 1'b0);

`ifdef AUTO_RELOAD_EN
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("reload_preset2", 6'd2, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    step(8);
    check("reload_alarm", 6'd0, 1'b1, 1'b0);
    step(19);
    check("reload_alarm_last", 6'd0, 1'b1, 1'b0);
    step(1);
    check("reload_run", 6'd2, 1'b0, 1'b1);
    step(3);
    check("reload_before_tick", 6'd2, 1'b0, 1'b1);
    step(1);
    check("reload_tick", 6'd1, 1'b0, 1'b1);
    step(4);
    check("reload_alarm2", 6'd0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("reload_ack_idle", 6'd2, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
